// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 8-digit seven-segment driver.
// Glyphs are active-low, bit order g..a.
package seg7_scan_driver_pkg;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dot;
    logic [7:0]  en;
  } disp_t;

endpackage

// File: rtl/seg7_scan_driver_hex7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (g..a).
module hex7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with frame-aligned updates:
// new content is staged in pending registers and only swapped in at a frame boundary.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dot,
  input  logic [7:0]  en,
  input  logic        load,
  output logic        pend,
  output logic        frame,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int CW = 20;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          tick;
  logic          boundary;
  disp_t         pending;
  disp_t         active;
  disp_t         incoming;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign tick     = (cnt == DIV_M1);
  assign boundary = tick & (idx == 3'd7);
  assign frame    = boundary & ~rst;
  assign incoming = '{data: data, dot: dot, en: en};
  assign nib      = active.data[{idx, 2'b00} +: 4];

  hex7_decode u_dec (
    .hex (nib),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 3'd0;
      pend    <= 1'b0;
      pending <= '0;
      active  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= idx + 3'd1;
      end
      // A load landing on the boundary bypasses pending so it shows this frame.
      if (load && boundary) begin
        active <= incoming;
        pend   <= 1'b0;
      end else if (load) begin
        pending <= incoming;
        pend    <= 1'b1;
      end else if (boundary && pend) begin
        active <= pending;
        pend   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SEG <= SEG_BLANK;
      AN  <= AN_OFF;
    end else if (!active.en[idx]) begin
      SEG <= SEG_BLANK;
      AN  <= AN_OFF;
    end else begin
      SEG <= {~active.dot[idx], glyph};
      AN  <= ~(8'd1 << idx);
    end
  end

endmodule
